decode_execute_stage: RTL and testbench

Decode-to-execute boundary of the pipelined core. Contains the 16x32 register file, the ID/EX pipeline register, and load-use hazard detection. Every register-read operand, register index and control flag consumed by the execute-stage forwarding logic comes from this block's outputs. Upstream decode is stalled when needed, and bubbles are inserted on load-use hazards and branch flushes.

---
 rtl/decode_execute_stage.sv | 165 ++++++++++++++++
 tb/tb_decode_execute_stage.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_execute_stage.sv
// Decode/execute boundary: 16x32 register file, ID/EX register, load-use hazard.
// Optional statistics counters are built when DECODE_STATS_EN is defined.
module decode_execute_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4,
    parameter int NUM_REGS   = 2**REG_ADDR_W,
    parameter int CTRL_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dec_valid,
    input  logic [REG_ADDR_W-1:0] dec_r1,
    input  logic [REG_ADDR_W-1:0] dec_r2,
    input  logic [REG_ADDR_W-1:0] dec_rdest,
    input  logic [DATA_W-1:0]     dec_imm,
    input  logic                  dec_immediate,
    input  logic                  dec_branch,
    input  logic                  dec_regw,
    input  logic                  dec_memread,
    input  logic [CTRL_W-1:0]     dec_ctrl,
    input  logic                  wb_regw,
    input  logic [REG_ADDR_W-1:0] wb_rdest,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  flush,
    input  logic                  ex_stall,
    output logic                  dec_stall,
    output logic                  ex_valid,
    output logic                  ex_branch,
    output logic                  ex_immediate,
    output logic                  ex_regw,
    output logic                  ex_memread,
    output logic [REG_ADDR_W-1:0] ex_r1,
    output logic [REG_ADDR_W-1:0] ex_r2,
    output logic [REG_ADDR_W-1:0] ex_rdest,
    output logic [DATA_W-1:0]     ex_a,
    output logic [DATA_W-1:0]     ex_b,
    output logic [CTRL_W-1:0]     ex_ctrl,
    output logic [15:0]           bubble_cnt,
    output logic [15:0]           flush_cnt
);

    logic [DATA_W-1:0] rf [NUM_REGS];

    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

    logic load_use;
    logic hit_r1;
    logic hit_r2;
    logic do_flush;
    logic do_hold;
    logic do_bubble;
    logic do_load;
    logic ref_a;
    logic ref_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf[i] <= '0;
            end
        end else if (wb_regw) begin
            rf[wb_rdest] <= wb_data;
        end
    end

    // Same-cycle writeback bypasses the array so decode never sees stale data.
    always_comb begin
        rd1 = rf[dec_r1];
        rd2 = rf[dec_r2];
        if (wb_regw && (wb_rdest == dec_r1)) rd1 = wb_data;
        if (wb_regw && (wb_rdest == dec_r2)) rd2 = wb_data;
        op_a = rd1;
        op_b = dec_immediate ? dec_imm : rd2;
    end

    always_comb begin
        hit_r1   = (dec_r1 == ex_rdest) && !dec_branch;
        hit_r2   = (dec_r2 == ex_rdest) && !dec_immediate;
        load_use = ex_valid && ex_memread && ex_regw && dec_valid
                   && (hit_r1 || hit_r2);
    end

    assign dec_stall = !rst && !flush && (ex_stall || load_use);

    always_comb begin
        do_flush  = flush;
        do_hold   = !flush && ex_stall;
        do_bubble = !flush && !ex_stall && load_use;
        do_load   = !flush && !ex_stall && !load_use;
        ref_a     = wb_regw && (wb_rdest == ex_r1) && !ex_branch;
        ref_b     = wb_regw && (wb_rdest == ex_r2) && !ex_immediate;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_branch    <= 1'b0;
            ex_immediate <= 1'b0;
            ex_regw      <= 1'b0;
            ex_memread   <= 1'b0;
            ex_r1        <= '0;
            ex_r2        <= '0;
            ex_rdest     <= '0;
            ex_a         <= '0;
            ex_b         <= '0;
            ex_ctrl      <= '0;
        end else begin
            unique case (1'b1)
                do_flush: begin
                    ex_valid   <= 1'b0;
                    ex_regw    <= 1'b0;
                    ex_memread <= 1'b0;
                    ex_branch  <= 1'b0;
                end
                // Held operands track writeback so the stalled op stays current.
                do_hold: begin
                    if (ref_a) ex_a <= wb_data;
                    if (ref_b) ex_b <= wb_data;
                end
                do_bubble: begin
                    ex_valid   <= 1'b0;
                    ex_regw    <= 1'b0;
                    ex_memread <= 1'b0;
                end
                do_load: begin
                    ex_valid     <= dec_valid;
                    ex_branch    <= dec_branch;
                    ex_immediate <= dec_immediate;
                    ex_regw      <= dec_regw;
                    ex_memread   <= dec_memread;
                    ex_r1        <= dec_r1;
                    ex_r2        <= dec_r2;
                    ex_rdest     <= dec_rdest;
                    ex_a         <= op_a;
                    ex_b         <= op_b;
                    ex_ctrl      <= dec_ctrl;
                end
                default: ;
            endcase
        end
    end

`ifdef DECODE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (do_bubble && (bubble_cnt != 16'hFFFF)) begin
                bubble_cnt <= bubble_cnt + 16'd1;
            end
            if (do_flush && (flush_cnt != 16'hFFFF)) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end
`else
    assign bubble_cnt = '0;
    assign flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_decode_execute_stage.sv
// Directed testbench for decode_execute_stage.
// Counter expectations follow DECODE_STATS_EN.
module tb_decode_execute_stage;

`ifdef DECODE_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid;
    logic [3:0]  dec_r1;
    logic [3:0]  dec_r2;
    logic [3:0]  dec_rdest;
    logic [31:0] dec_imm;
    logic        dec_immediate;
    logic        dec_branch;
    logic        dec_regw;
    logic        dec_memread;
    logic [7:0]  dec_ctrl;
    logic        wb_regw;
    logic [3:0]  wb_rdest;
    logic [31:0] wb_data;
    logic        flush;
    logic        ex_stall;
    logic        dec_stall;
    logic        ex_valid;
    logic        ex_branch;
    logic        ex_immediate;
    logic        ex_regw;
    logic        ex_memread;
    logic [3:0]  ex_r1;
    logic [3:0]  ex_r2;
    logic [3:0]  ex_rdest;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [7:0]  ex_ctrl;
    logic [15:0] bubble_cnt;
    logic [15:0] flush_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    decode_execute_stage dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_r1(dec_r1), .dec_r2(dec_r2),
        .dec_rdest(dec_rdest), .dec_imm(dec_imm),
        .dec_immediate(dec_immediate), .dec_branch(dec_branch),
        .dec_regw(dec_regw), .dec_memread(dec_memread),
        .dec_ctrl(dec_ctrl), .wb_regw(wb_regw), .wb_rdest(wb_rdest),
        .wb_data(wb_data), .flush(flush), .ex_stall(ex_stall),
        .dec_stall(dec_stall), .ex_valid(ex_valid),
        .ex_branch(ex_branch), .ex_immediate(ex_immediate),
        .ex_regw(ex_regw), .ex_memread(ex_memread), .ex_r1(ex_r1),
        .ex_r2(ex_r2), .ex_rdest(ex_rdest), .ex_a(ex_a), .ex_b(ex_b),
        .ex_ctrl(ex_ctrl), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic dec_set(input logic v, input logic [3:0] r1,
                           input logic [3:0] r2, input logic [3:0] rd,
                           input logic [31:0] imm, input logic immd,
                           input logic br, input logic rw, input logic mr,
                           input logic [7:0] ctl);
        dec_valid = v; dec_r1 = r1; dec_r2 = r2; dec_rdest = rd;
        dec_imm = imm; dec_immediate = immd; dec_branch = br;
        dec_regw = rw; dec_memread = mr; dec_ctrl = ctl;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dec_set(1'b1, 4'd5, 4'd5, 4'd5, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h0);
        wb_regw = 1'b0; wb_rdest = '0; wb_data = '0;
        flush = 1'b0; ex_stall = 1'b1;
        #1;
        n_cmp++;
        if (dec_stall !== 1'b0) begin
            n_bad++; $display("FAIL reset_dec_stall got %b exp 0", dec_stall);
        end
        step(); step();
        n_cmp++;
        if ({ex_valid, ex_regw, ex_memread, ex_branch, ex_immediate} !== 5'b0) begin
            n_bad++; $display("FAIL reset_flags got %b exp 0",
                {ex_valid, ex_regw, ex_memread, ex_branch, ex_immediate});
        end
        n_cmp++;
        if ({ex_a, ex_b, ex_ctrl, ex_r1, ex_r2, ex_rdest} !== '0) begin
            n_bad++; $display("FAIL reset_fields got a=%h b=%h exp 0", ex_a, ex_b);
        end
        n_cmp++;
        if ({bubble_cnt, flush_cnt} !== 32'h0) begin
            n_bad++; $display("FAIL reset_cnt got %h/%h exp 0", bubble_cnt, flush_cnt);
        end
        rst = 1'b0; ex_stall = 1'b0;
        dec_set(1'b0, 4'd0, 4'd0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0);
        step();
    endtask

    task automatic test_write_through();
        wb_regw = 1'b1; wb_rdest = 4'd3; wb_data = 32'hDEADBEEF;
        dec_set(1'b1, 4'd3, 4'd0, 4'd1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11);
        step();
        n_cmp++;
        if (ex_a !== 32'hDEADBEEF || ex_valid !== 1'b1) begin
            n_bad++; $display("FAIL wt_bypass got a=%h v=%b exp deadbeef 1", ex_a, ex_valid);
        end
        wb_rdest = 4'd2; wb_data = 32'h22;
        dec_set(1'b1, 4'd0, 4'd0, 4'd1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11);
        step();
        wb_regw = 1'b0;
        dec_set(1'b1, 4'd3, 4'd2, 4'd4, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A);
        step();
        n_cmp++;
        if (ex_a !== 32'hDEADBEEF || ex_b !== 32'h22) begin
            n_bad++; $display("FAIL rf_read got a=%h b=%h exp deadbeef 22", ex_a, ex_b);
        end
        n_cmp++;
        if (ex_ctrl !== 8'h5A || ex_rdest !== 4'd4) begin
            n_bad++; $display("FAIL passthru got ctl=%h rd=%h exp 5a 4", ex_ctrl, ex_rdest);
        end
    endtask

    task automatic test_load_use();
        dec_set(1'b1, 4'd0, 4'd0, 4'd5, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h01);
        step();
        dec_set(1'b1, 4'd1, 4'd5, 4'd6, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h02);
        #1;
        n_cmp++;
        if (dec_stall !== 1'b1) begin
            n_bad++; $display("FAIL lu_stall got %b exp 1", dec_stall);
        end
        step();
        n_cmp++;
        if (ex_valid !== 1'b0 || ex_regw !== 1'b0 || ex_memread !== 1'b0) begin
            n_bad++; $display("FAIL lu_bubble got v=%b w=%b m=%b exp 0 0 0",
                ex_valid, ex_regw, ex_memread);
        end
        n_cmp++;
        if (dec_stall !== 1'b0) begin
            n_bad++; $display("FAIL lu_release got %b exp 0", dec_stall);
        end
        step();
        n_cmp++;
        if (ex_valid !== 1'b1 || ex_r2 !== 4'd5 || ex_rdest !== 4'd6) begin
            n_bad++; $display("FAIL lu_issue got v=%b r2=%h rd=%h exp 1 5 6",
                ex_valid, ex_r2, ex_rdest);
        end
        n_cmp++;
        if (bubble_cnt !== 16'(STATS)) begin
            n_bad++; $display("FAIL lu_bubble_cnt got %0d exp %0d", bubble_cnt, STATS);
        end
    endtask

    task automatic test_no_false_hazard();
        dec_set(1'b1, 4'd0, 4'd0, 4'd5, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h01);
        step();
        dec_set(1'b1, 4'd0, 4'd5, 4'd7, 32'h10, 1'b1, 1'b0, 1'b1, 1'b0, 8'h03);
        #1;
        n_cmp++;
        if (dec_stall !== 1'b0) begin
            n_bad++; $display("FAIL nfh_imm_stall got %b exp 0", dec_stall);
        end
        step();
        n_cmp++;
        if (ex_b !== 32'h10 || ex_valid !== 1'b1) begin
            n_bad++; $display("FAIL nfh_imm got b=%h v=%b exp 10 1", ex_b, ex_valid);
        end
        dec_set(1'b1, 4'd0, 4'd0, 4'd5, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h01);
        step();
        dec_set(1'b1, 4'd5, 4'd0, 4'd0, 32'h4, 1'b1, 1'b1, 1'b0, 1'b0, 8'h04);
        #1;
        n_cmp++;
        if (dec_stall !== 1'b0) begin
            n_bad++; $display("FAIL nfh_branch_stall got %b exp 0", dec_stall);
        end
        step();
        n_cmp++;
        if (ex_branch !== 1'b1 || bubble_cnt !== 16'(STATS)) begin
            n_bad++; $display("FAIL nfh_branch got br=%b cnt=%0d exp 1 %0d",
                ex_branch, bubble_cnt, STATS);
        end
    endtask

    task automatic test_flush_over_stall();
        dec_set(1'b1, 4'd0, 4'd0, 4'd8, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h06);
        step();
        ex_stall = 1'b1; flush = 1'b1;
        #1;
        n_cmp++;
        if (dec_stall !== 1'b0) begin
            n_bad++; $display("FAIL fl_dec_stall got %b exp 0", dec_stall);
        end
        step();
        flush = 1'b0; ex_stall = 1'b0;
        n_cmp++;
        if (ex_valid !== 1'b0 || ex_regw !== 1'b0 || ex_branch !== 1'b0) begin
            n_bad++; $display("FAIL fl_squash got v=%b w=%b br=%b exp 0 0 0",
                ex_valid, ex_regw, ex_branch);
        end
        n_cmp++;
        if (flush_cnt !== 16'(STATS)) begin
            n_bad++; $display("FAIL fl_cnt got %0d exp %0d", flush_cnt, STATS);
        end
    endtask

    task automatic test_refresh();
        dec_set(1'b1, 4'd7, 4'd8, 4'd9, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5);
        step();
        ex_stall = 1'b1;
        wb_regw = 1'b1; wb_rdest = 4'd7; wb_data = 32'h1234;
        dec_set(1'b1, 4'd1, 4'd2, 4'd3, 32'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        #1;
        n_cmp++;
        if (dec_stall !== 1'b1) begin
            n_bad++; $display("FAIL rf_dec_stall got %b exp 1", dec_stall);
        end
        step();
        wb_regw = 1'b0;
        n_cmp++;
        if (ex_a !== 32'h1234 || ex_b !== 32'h0) begin
            n_bad++; $display("FAIL rf_refresh got a=%h b=%h exp 1234 0", ex_a, ex_b);
        end
        n_cmp++;
        if ({ex_valid, ex_regw, ex_memread, ex_immediate} !== 4'b1100
            || ex_r1 !== 4'd7 || ex_r2 !== 4'd8 || ex_rdest !== 4'd9
            || ex_ctrl !== 8'hA5) begin
            n_bad++; $display("FAIL rf_hold got r1=%h r2=%h rd=%h ctl=%h exp 7 8 9 a5",
                ex_r1, ex_r2, ex_rdest, ex_ctrl);
        end
        ex_stall = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_stall();
        dec_set(1'b1, 4'd0, 4'd0, 4'd5, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h07);
        step();
        dec_set(1'b1, 4'd5, 4'd0, 4'd1, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h08);
        ex_stall = 1'b1; rst = 1'b1;
        #1;
        n_cmp++;
        if (dec_stall !== 1'b0) begin
            n_bad++; $display("FAIL rms_dec_stall got %b exp 0", dec_stall);
        end
        step();
        rst = 1'b0; ex_stall = 1'b0;
        n_cmp++;
        if ({ex_valid, ex_regw, ex_memread, ex_branch, ex_immediate} !== 5'b0
            || {ex_a, ex_b, ex_ctrl, ex_r1, ex_r2, ex_rdest} !== '0) begin
            n_bad++; $display("FAIL rms_clear got v=%b a=%h rd=%h exp 0",
                ex_valid, ex_a, ex_rdest);
        end
        n_cmp++;
        if ({bubble_cnt, flush_cnt} !== 32'h0) begin
            n_bad++; $display("FAIL rms_cnt got %h/%h exp 0", bubble_cnt, flush_cnt);
        end
        for (int i = 1; i < 16; i++) begin
            dec_set(1'b1, 4'(i), 4'(i), 4'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0);
            step();
            n_cmp++;
            if (ex_a !== 32'h0 || ex_b !== 32'h0) begin
                n_bad++; $display("FAIL rms_rf r%0d got a=%h b=%h exp 0", i, ex_a, ex_b);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_write_through();
        test_load_use();
        test_no_false_hazard();
        test_flush_over_stall();
        test_refresh();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
